// File: rtl/ram_dp_be.sv
// True dual-port byte-enable RAM with selectable read latency, same-port write mode,
// cross-port collision flag and a post-reset clear engine that zeroes every word.
module ram_dp_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LAT       = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_en,
  input  logic                  a_write_en,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_write_en,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_valid,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run;
  logic                a_acc, b_acc, a_wr, b_wr;

  logic [DATA_W-1:0]   a_data_p0, b_data_p0;
  logic                a_vld_p0, b_vld_p0, coll_p0;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Requests are only honoured in RUN and never in a reset cycle.
  assign run   = (state == ST_RUN) && !reset;
  assign a_acc = a_en && run;
  assign b_acc = b_en && run;
  assign a_wr  = a_acc && a_write_en;
  assign b_wr  = b_acc && b_write_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state     <= ST_INIT;
        init_busy <= 1'b1;
      end else begin
        state     <= ST_RUN;
        init_busy <= 1'b0;
      end
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // B bytes are scheduled first so A's later assignment wins on a shared address.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Stage p0: array read; held when the port is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_vld_p0  <= 1'b0;
      b_vld_p0  <= 1'b0;
      coll_p0   <= 1'b0;
      a_data_p0 <= '0;
      b_data_p0 <= '0;
    end else begin
      a_vld_p0 <= a_acc;
      b_vld_p0 <= b_acc;
      coll_p0  <= a_acc && b_acc && (a_addr == b_addr) && (a_write_en || b_write_en);
      if (a_acc) begin
        a_data_p0 <= ((WRITE_MODE != 0) && a_write_en) ?
                     merge_be(mem[a_addr], a_wdata, a_be) : mem[a_addr];
      end
      if (b_acc) begin
        b_data_p0 <= ((WRITE_MODE != 0) && b_write_en) ?
                     merge_be(mem[b_addr], b_wdata, b_be) : mem[b_addr];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] a_data_p1, b_data_p1;
      logic              a_vld_p1, b_vld_p1, coll_p1;

      // Stage p1: optional output register.
      always_ff @(posedge clock) begin
        if (reset) begin
          a_vld_p1  <= 1'b0;
          b_vld_p1  <= 1'b0;
          coll_p1   <= 1'b0;
          a_data_p1 <= '0;
          b_data_p1 <= '0;
        end else begin
          a_vld_p1 <= a_vld_p0;
          b_vld_p1 <= b_vld_p0;
          coll_p1  <= coll_p0;
          if (a_vld_p0) a_data_p1 <= a_data_p0;
          if (b_vld_p0) b_data_p1 <= b_data_p0;
        end
      end

      assign a_rdata   = a_data_p1;
      assign b_rdata   = b_data_p1;
      assign a_valid   = a_vld_p1;
      assign b_valid   = b_vld_p1;
      assign collision = coll_p1;
    end else begin : g_lat1
      assign a_rdata   = a_data_p0;
      assign b_rdata   = b_data_p0;
      assign a_valid   = a_vld_p0;
      assign b_valid   = b_vld_p0;
      assign collision = coll_p0;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (READ_LAT=1/read-first, READ_LAT=2/write-first)
// share one stimulus stream; a memory model feeds per-port expected-result queues.
module tb_ram_dp_be;
  localparam int DEPTH = 1024;

  logic        clock;
  logic        reset;
  logic        a_en, a_write_en, b_en, b_write_en;
  logic [3:0]  a_be, b_be;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic        a_v0, b_v0, a_v1, b_v1, busy0, busy1, coll0, coll1;

  ram_dp_be #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clock), .reset(reset),
    .a_en(a_en), .a_write_en(a_write_en), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rd0), .a_valid(a_v0),
    .b_en(b_en), .b_write_en(b_write_en), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rd0), .b_valid(b_v0),
    .init_busy(busy0), .collision(coll0));

  ram_dp_be #(.DATA_W(32), .ADDR_W(10), .READ_LAT(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset(reset),
    .a_en(a_en), .a_write_en(a_write_en), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rd1), .a_valid(a_v1),
    .b_en(b_en), .b_write_en(b_write_en), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rd1), .b_valid(b_v1),
    .init_busy(busy1), .collision(coll1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] d;
  } ent_t;

  ent_t        q[4][$];
  int          cq[2][$];
  logic [31:0] last[4];
  logic [31:0] model[DEPTH];
  int          cyc, vectors, miscompares;
  bit          run_m, busy_exp, chk_busy;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check_port(input int p, input string tag, input logic v, input logic [31:0] rd);
    logic ev;
    ev = (q[p].size() > 0) && (q[p][0].due == cyc);
    vectors++;
    assert (v === ev) else begin
      miscompares++;
      $error("FAIL %s_valid cyc %0d: got %b expected %b", tag, cyc, v, ev);
    end
    if (ev) begin
      last[p] = q[p][0].d;
      void'(q[p].pop_front());
    end
    vectors++;
    assert (rd === last[p]) else begin
      miscompares++;
      $error("FAIL %s_rdata cyc %0d: got %h expected %h", tag, cyc, rd, last[p]);
    end
  endtask

  task automatic check_coll(input int d, input logic c);
    logic ec;
    ec = (cq[d].size() > 0) && (cq[d][0] == cyc);
    if (ec) void'(cq[d].pop_front());
    vectors++;
    assert (c === ec) else begin
      miscompares++;
      $error("FAIL dut%0d_collision cyc %0d: got %b expected %b", d, cyc, c, ec);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    check_port(0, "dut0_a", a_v0, a_rd0);
    check_port(1, "dut0_b", b_v0, b_rd0);
    check_port(2, "dut1_a", a_v1, a_rd1);
    check_port(3, "dut1_b", b_v1, b_rd1);
    check_coll(0, coll0);
    check_coll(1, coll1);
    if (chk_busy) begin
      vectors++;
      assert (busy0 === busy_exp) else begin
        miscompares++;
        $error("FAIL dut0_init_busy cyc %0d: got %b expected %b", cyc, busy0, busy_exp);
      end
      vectors++;
      assert (busy1 === busy_exp) else begin
        miscompares++;
        $error("FAIL dut1_init_busy cyc %0d: got %b expected %b", cyc, busy1, busy_exp);
      end
    end
  endtask

  task automatic apply(input bit ae, input bit awe, input logic [3:0] abe,
                       input logic [9:0] aad, input logic [31:0] awd,
                       input bit be_, input bit bwe, input logic [3:0] bbe,
                       input logic [9:0] bad, input logic [31:0] bwd);
    ent_t e;
    a_en = ae; a_write_en = awe; a_be = abe; a_addr = aad; a_wdata = awd;
    b_en = be_; b_write_en = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
    if (run_m) begin
      for (int d = 0; d < 2; d++) begin
        e.due = cyc + d + 1;
        if (ae) begin
          e.d = (awe && d == 1) ? merge(model[aad], awd, abe) : model[aad];
          q[2*d].push_back(e);
        end
        if (be_) begin
          e.d = (bwe && d == 1) ? merge(model[bad], bwd, bbe) : model[bad];
          q[2*d+1].push_back(e);
        end
        if (ae && be_ && aad == bad && (awe || bwe)) cq[d].push_back(cyc + d + 1);
      end
      if (be_ && bwe) model[bad] = merge(model[bad], bwd, bbe);
      if (ae && awe) model[aad] = merge(model[aad], awd, abe);
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) apply(0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic wr_a(input logic [9:0] ad, input logic [31:0] wd, input logic [3:0] be);
    apply(1, 1, be, ad, wd, 0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic rd_a(input logic [9:0] ad);
    apply(1, 0, 4'h0, ad, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic wr_b(input logic [9:0] ad, input logic [31:0] wd, input logic [3:0] be);
    apply(0, 0, 4'h0, 10'h0, 32'h0, 1, 1, be, ad, wd);
  endtask

  task automatic rd_b(input logic [9:0] ad);
    apply(0, 0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, ad, 32'h0);
  endtask

  task automatic rand_wr_a();
    apply(1, 1, 4'($urandom), 10'($urandom_range(0, 15)), $urandom | 32'h1,
          0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  // Holds reset for n edges; the sample after the last one is the first busy cycle.
  task automatic do_reset(input int n);
    chk_busy = 0;
    run_m    = 0;
    for (int p = 0; p < 4; p++) begin
      q[p].delete();
      last[p] = '0;
    end
    cq[0].delete();
    cq[1].delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
    vectors++;
    assert (busy0 === 1'b1 && busy1 === 1'b1) else begin
      miscompares++;
      $error("FAIL init_busy_first cyc %0d: got %b/%b expected 1/1", cyc, busy0, busy1);
    end
    chk_busy = 1;
    busy_exp = 1;
  endtask

  // Remaining 1023 busy cycles, the first idle sample, then model accepts accesses.
  task automatic finish_init(input bit hammer);
    repeat (DEPTH - 1) begin
      if (hammer) rand_wr_a(); else idle(1);
    end
    busy_exp = 0;
    if (hammer) rand_wr_a(); else idle(1);
    run_m = 1;
  endtask

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    run_m = 0; busy_exp = 0; chk_busy = 0;
    a_en = 0; a_write_en = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_en = 0; b_write_en = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    reset = 1'b1;

    do_reset(2);
    finish_init(0);

    rd_b(10'h3FF);
    idle(3);

    wr_a(10'd5, 32'hAABBCCDD, 4'hF);
    wr_a(10'd5, 32'h11223344, 4'h5);
    rd_a(10'd5);
    idle(3);

    wr_a(10'd5, 32'h00000000, 4'hF);
    idle(3);
    rd_a(10'd5);
    wr_a(10'd5, 32'hFFFFFFFF, 4'h0);
    rd_a(10'd5);
    idle(3);

    apply(1, 1, 4'h3, 10'd7, 32'h11111111, 1, 1, 4'hF, 10'd7, 32'h22222222);
    idle(3);
    rd_a(10'd7);
    rd_b(10'd7);
    idle(3);

    apply(1, 1, 4'hF, 10'd7, 32'hDEADBEEF, 1, 0, 4'h0, 10'd7, 32'h0);
    apply(1, 0, 4'h0, 10'd7, 32'h0, 1, 1, 4'hC, 10'd7, 32'h5A5A0000);
    apply(1, 0, 4'h0, 10'd7, 32'h0, 1, 0, 4'h0, 10'd7, 32'h0);
    apply(1, 1, 4'hF, 10'd8, 32'h01020304, 1, 1, 4'hF, 10'd9, 32'hA0B0C0D0);
    apply(1, 0, 4'h0, 10'd9, 32'h0, 1, 0, 4'h0, 10'd8, 32'h0);
    idle(3);

    wr_b(10'd1, 32'h0000_0001, 4'hF);
    wr_b(10'd2, 32'h0000_0002, 4'hF);
    wr_b(10'd3, 32'h0000_0003, 4'hF);
    idle(1);
    rd_b(10'd1);
    rd_b(10'd2);
    rd_b(10'd3);
    idle(4);

    for (int i = 0; i < 200; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            10'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            10'($urandom_range(0, 15)), $urandom);
    end
    idle(3);

    do_reset(1);
    repeat (500) rand_wr_a();
    do_reset(1);
    finish_init(1);
    for (int i = 0; i < 16; i++) rd_a(10'(i));
    rd_b(10'h3FF);
    rd_b(10'h200);
    idle(4);

    for (int p = 0; p < 4; p++) begin
      vectors++;
      assert (q[p].size() == 0) else begin
        miscompares++;
        $error("FAIL drain_port%0d: got %0d pending expected 0", p, q[p].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
